// File: rtl/stack_param_if.sv
// Operand-stack bus between the stack_param register stack and its user.
// Carries the command inputs (clr/push/pop/d) and the visible stack state.
// When STACK_SWAP_EN is defined the bus also carries the swap command.
interface stack_param_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             clr;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] d;
`ifdef STACK_SWAP_EN
    logic             swap;
`endif
    logic [WIDTH-1:0] qtop;
    logic [WIDTH-1:0] qnext;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             udf;

    // The user of the stack issues commands and observes the stack state
    modport master (
        output clr, push, pop, d,
`ifdef STACK_SWAP_EN
        output swap,
`endif
        input  qtop, qnext, count, empty, full, ovf, udf
    );

    // The stack itself receives commands and presents its state
    modport slave (
        input  clr, push, pop, d,
`ifdef STACK_SWAP_EN
        input  swap,
`endif
        output qtop, qnext, count, empty, full, ovf, udf
    );
endinterface

// File: rtl/stack_param.sv
// Parametrised LIFO register stack with occupancy count, empty/full flags,
// replace-top (push+pop), sticky overflow/underflow flags and synchronous
// clear. The top two entries are always visible for the operand bus.
// Optional feature: define STACK_SWAP_EN to add a swap command that
// exchanges the top two entries (priority clr > swap > push/pop).
module stack_param #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    stack_param_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [CW-1:0] TWO_CNT  = CW'(2);

    logic [WIDTH-1:0] q [DEPTH];
    logic [CW-1:0]    cnt;
    logic             ovf_r;
    logic             udf_r;
    logic             is_empty;
    logic             is_full;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == FULL_CNT);

    // Stack array, occupancy and sticky error flags; vacated slots are zero-filled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end
`ifdef STACK_SWAP_EN
        else if (bus.swap) begin
            if (cnt >= TWO_CNT) begin
                q[0] <= q[1];
                q[1] <= q[0];
            end else begin
                udf_r <= 1'b1;
            end
        end
`endif
        else if (bus.push && bus.pop) begin
            if (is_empty) begin
                // Replace-top on an empty stack behaves as a plain push
                q[0] <= bus.d;
                for (int i = 1; i < DEPTH; i++) q[i] <= q[i-1];
                cnt <= ONE_CNT;
            end else begin
                q[0] <= bus.d;
            end
        end else if (bus.push) begin
            q[0] <= bus.d;
            for (int i = 1; i < DEPTH; i++) q[i] <= q[i-1];
            if (is_full) begin
                ovf_r <= 1'b1;
            end else begin
                cnt <= cnt + ONE_CNT;
            end
        end else if (bus.pop) begin
            if (is_empty) begin
                udf_r <= 1'b1;
            end else begin
                for (int i = 0; i < DEPTH - 1; i++) q[i] <= q[i+1];
                q[DEPTH-1] <= '0;
                cnt <= cnt - ONE_CNT;
            end
        end
    end

    assign bus.qtop  = q[0];
    assign bus.qnext = q[1];
    assign bus.count = cnt;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.ovf   = ovf_r;
    assign bus.udf   = udf_r;
endmodule

// File: tb/tb_stack_param.sv
// Self-checking bench for stack_param (DEPTH=4, WIDTH=16).
// Directed scenarios use literal expected values; the random scenario is
// checked against a queue-based LIFO model. Swap scenarios are compiled in
// when STACK_SWAP_EN is defined.
module tb_stack_param;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: front of queue is the top of stack
    logic [WIDTH-1:0] mq[$];
    bit               movf;
    bit               mudf;

    stack_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] exp_top();
        return (mq.size() > 0) ? mq[0] : '0;
    endfunction

    function automatic logic [WIDTH-1:0] exp_next();
        return (mq.size() > 1) ? mq[1] : '0;
    endfunction

    task automatic model_reset();
        mq.delete();
        movf = 1'b0;
        mudf = 1'b0;
    endtask

    // Apply one command to the LIFO model
    task automatic model_step(input bit c, input bit pu, input bit po,
                              input bit sw, input logic [WIDTH-1:0] dv);
        logic [WIDTH-1:0] tmp;
        if (c) begin
            model_reset();
        end else if (sw) begin
            if (mq.size() >= 2) begin
                tmp   = mq[0];
                mq[0] = mq[1];
                mq[1] = tmp;
            end else begin
                mudf = 1'b1;
            end
        end else if (pu && po && mq.size() > 0) begin
            mq[0] = dv;
        end else if (pu) begin
            mq.push_front(dv);
            if (mq.size() > DEPTH) begin
                void'(mq.pop_back());
                movf = 1'b1;
            end
        end else if (po) begin
            if (mq.size() == 0) mudf = 1'b1;
            else void'(mq.pop_front());
        end
    endtask

    task automatic set_idle();
        bus.clr  = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.d    = '0;
`ifdef STACK_SWAP_EN
        bus.swap = 1'b0;
`endif
    endtask

    // Drive one command across a rising edge; returns #1 after the edge
    task automatic cycle(input bit c, input bit pu, input bit po,
                         input bit sw, input logic [WIDTH-1:0] dv);
        bus.clr  = c;
        bus.push = pu;
        bus.pop  = po;
        bus.d    = dv;
`ifdef STACK_SWAP_EN
        bus.swap = sw;
`endif
        @(posedge clk);
`ifdef STACK_SWAP_EN
        model_step(c, pu, po, sw, dv);
`else
        model_step(c, pu, po, 1'b0, dv);
`endif
        #1;
        set_idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        model_reset();
        #12;
        checks++; if (bus.qtop !== 16'h0) begin failures++; $display("[TB] FAIL reset_qtop got %h exp 0000", bus.qtop); end
        checks++; if (bus.qnext !== 16'h0) begin failures++; $display("[TB] FAIL reset_qnext got %h exp 0000", bus.qnext); end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count got %0d exp 0", bus.count); end
        checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags empty=%b full=%b exp 1 0", bus.empty, bus.full); end
        checks++; if (bus.ovf !== 1'b0 || bus.udf !== 1'b0) begin failures++; $display("[TB] FAIL reset_err ovf=%b udf=%b exp 0 0", bus.ovf, bus.udf); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_push_three();
        cycle(1, 0, 0, 0, '0);
        cycle(0, 1, 0, 0, 16'h1111);
        cycle(0, 1, 0, 0, 16'h2222);
        cycle(0, 1, 0, 0, 16'h3333);
        checks++; if (bus.qtop !== 16'h3333) begin failures++; $display("[TB] FAIL push3_qtop got %h exp 3333", bus.qtop); end
        checks++; if (bus.qnext !== 16'h2222) begin failures++; $display("[TB] FAIL push3_qnext got %h exp 2222", bus.qnext); end
        checks++; if (bus.count !== 3'd3) begin failures++; $display("[TB] FAIL push3_count got %0d exp 3", bus.count); end
        checks++; if (bus.empty !== 1'b0 || bus.full !== 1'b0) begin failures++; $display("[TB] FAIL push3_flags empty=%b full=%b exp 0 0", bus.empty, bus.full); end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] pops [4] = '{16'hE, 16'hD, 16'hC, 16'hB};
        cycle(1, 0, 0, 0, '0);
        cycle(0, 1, 0, 0, 16'hA);
        cycle(0, 1, 0, 0, 16'hB);
        cycle(0, 1, 0, 0, 16'hC);
        cycle(0, 1, 0, 0, 16'hD);
        checks++; if (bus.full !== 1'b1 || bus.ovf !== 1'b0) begin failures++; $display("[TB] FAIL full4_flags full=%b ovf=%b exp 1 0", bus.full, bus.ovf); end
        cycle(0, 1, 0, 0, 16'hE);
        checks++; if (bus.count !== 3'd4) begin failures++; $display("[TB] FAIL ovf_count got %0d exp 4", bus.count); end
        checks++; if (bus.full !== 1'b1 || bus.ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flags full=%b ovf=%b exp 1 1", bus.full, bus.ovf); end
        checks++; if (bus.qtop !== 16'hE || bus.qnext !== 16'hD) begin failures++; $display("[TB] FAIL ovf_data top=%h next=%h exp 000e 000d", bus.qtop, bus.qnext); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.qtop !== pops[i]) begin failures++; $display("[TB] FAIL ovf_pop%0d got %h exp %h", i, bus.qtop, pops[i]); end
            cycle(0, 0, 1, 0, '0);
        end
        checks++; if (bus.empty !== 1'b1 || bus.qtop !== 16'h0 || bus.qnext !== 16'h0) begin failures++; $display("[TB] FAIL ovf_drained empty=%b top=%h next=%h exp 1 0000 0000", bus.empty, bus.qtop, bus.qnext); end
        checks++; if (bus.ovf !== 1'b1 || bus.udf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_sticky ovf=%b udf=%b exp 1 0", bus.ovf, bus.udf); end
    endtask

    task automatic test_underflow();
        cycle(0, 0, 1, 0, '0);
        checks++; if (bus.count !== 3'd0 || bus.qtop !== 16'h0) begin failures++; $display("[TB] FAIL udf_state count=%0d top=%h exp 0 0000", bus.count, bus.qtop); end
        checks++; if (bus.udf !== 1'b1) begin failures++; $display("[TB] FAIL udf_flag got %b exp 1", bus.udf); end
        cycle(0, 0, 0, 0, '0);
        checks++; if (bus.udf !== 1'b1) begin failures++; $display("[TB] FAIL udf_sticky got %b exp 1", bus.udf); end
        cycle(1, 1, 1, 0, 16'hFFFF);
        checks++; if (bus.udf !== 1'b0 || bus.ovf !== 1'b0 || bus.count !== 3'd0) begin failures++; $display("[TB] FAIL clr_state udf=%b ovf=%b count=%0d exp 0 0 0", bus.udf, bus.ovf, bus.count); end
    endtask

    task automatic test_replace();
        cycle(1, 0, 0, 0, '0);
        cycle(0, 1, 0, 0, 16'h0005);
        cycle(0, 1, 0, 0, 16'h0007);
        cycle(0, 1, 1, 0, 16'h0009);
        checks++; if (bus.qtop !== 16'h0009 || bus.qnext !== 16'h0005) begin failures++; $display("[TB] FAIL repl_data top=%h next=%h exp 0009 0005", bus.qtop, bus.qnext); end
        checks++; if (bus.count !== 3'd2 || bus.udf !== 1'b0 || bus.ovf !== 1'b0) begin failures++; $display("[TB] FAIL repl_state count=%0d udf=%b ovf=%b exp 2 0 0", bus.count, bus.udf, bus.ovf); end
        cycle(1, 0, 0, 0, '0);
        cycle(0, 1, 1, 0, 16'h0042);
        checks++; if (bus.count !== 3'd1 || bus.qtop !== 16'h0042 || bus.qnext !== 16'h0) begin failures++; $display("[TB] FAIL repl_empty count=%0d top=%h next=%h exp 1 0042 0000", bus.count, bus.qtop, bus.qnext); end
        checks++; if (bus.udf !== 1'b0) begin failures++; $display("[TB] FAIL repl_empty_udf got %b exp 0", bus.udf); end
    endtask

    task automatic test_async_reset();
        cycle(1, 0, 0, 0, '0);
        cycle(0, 1, 0, 0, 16'h1234);
        checks++; if (bus.qtop !== 16'h1234) begin failures++; $display("[TB] FAIL arst_pre got %h exp 1234", bus.qtop); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.qtop !== 16'h0 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin failures++; $display("[TB] FAIL arst_mid top=%h count=%0d empty=%b exp 0000 0 1", bus.qtop, bus.count, bus.empty); end
        #2;
        rst_n = 1'b1;
    endtask

`ifdef STACK_SWAP_EN
    task automatic test_swap();
        cycle(1, 0, 0, 0, '0);
        cycle(0, 1, 0, 0, 16'h0001);
        cycle(0, 1, 0, 0, 16'h0002);
        cycle(0, 1, 1, 1, 16'hBEEF);
        checks++; if (bus.qtop !== 16'h0001 || bus.qnext !== 16'h0002) begin failures++; $display("[TB] FAIL swap_data top=%h next=%h exp 0001 0002", bus.qtop, bus.qnext); end
        checks++; if (bus.count !== 3'd2 || bus.udf !== 1'b0) begin failures++; $display("[TB] FAIL swap_state count=%0d udf=%b exp 2 0", bus.count, bus.udf); end
        cycle(1, 0, 0, 0, '0);
        cycle(0, 1, 0, 0, 16'h0005);
        cycle(0, 0, 0, 1, '0);
        checks++; if (bus.qtop !== 16'h0005 || bus.count !== 3'd1) begin failures++; $display("[TB] FAIL swap1_data top=%h count=%0d exp 0005 1", bus.qtop, bus.count); end
        checks++; if (bus.udf !== 1'b1) begin failures++; $display("[TB] FAIL swap1_udf got %b exp 1", bus.udf); end
    endtask
`endif

    task automatic test_random();
        logic [CW-1:0] ecnt;
        bit c, pu, po, sw;
        cycle(1, 0, 0, 0, '0);
        for (int n = 0; n < 400; n++) begin
            c  = ($urandom_range(0, 39) == 0);
            pu = $urandom_range(0, 1);
            po = $urandom_range(0, 1);
`ifdef STACK_SWAP_EN
            sw = ($urandom_range(0, 7) == 0);
`else
            sw = 1'b0;
`endif
            cycle(c, pu, po, sw, WIDTH'($urandom));
            ecnt = CW'(mq.size());
            checks++; if (bus.qtop !== exp_top()) begin failures++; $display("[TB] FAIL rnd_qtop n=%0d got %h exp %h", n, bus.qtop, exp_top()); end
            checks++; if (bus.qnext !== exp_next()) begin failures++; $display("[TB] FAIL rnd_qnext n=%0d got %h exp %h", n, bus.qnext, exp_next()); end
            checks++; if (bus.count !== ecnt) begin failures++; $display("[TB] FAIL rnd_count n=%0d got %0d exp %0d", n, bus.count, ecnt); end
            checks++; if (bus.empty !== (mq.size() == 0) || bus.full !== (mq.size() == DEPTH)) begin failures++; $display("[TB] FAIL rnd_flags n=%0d empty=%b full=%b size=%0d", n, bus.empty, bus.full, mq.size()); end
            checks++; if (bus.ovf !== movf || bus.udf !== mudf) begin failures++; $display("[TB] FAIL rnd_err n=%0d ovf=%b udf=%b exp %b %b", n, bus.ovf, bus.udf, movf, mudf); end
        end
    endtask

    initial begin
        test_reset();
        test_push_three();
        test_overflow();
        test_underflow();
        test_replace();
        test_async_reset();
`ifdef STACK_SWAP_EN
        test_swap();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stack_param.md
Name: stack_param

Overview:
- Parametrised LIFO register stack, the successor to the fixed 4-entry, 16-bit shift stack.
- Generalised in width and depth. Adds:
  - occupancy count, empty and full flags
  - push+pop "replace top" operation
  - sticky overflow and underflow error flags
  - synchronous clear
- Feeds the datapath operand bus: top and next-of-stack are always visible combinationally.

Parameters:
- WIDTH, 16: data width in bits.
- DEPTH, 8: number of entries; must be >= 2.
- CW, $clog2(DEPTH+1): count width; localparam, derived, not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of contents, count and error flags.
- push  input  1  push d onto stack.
- pop  input  1  pop top entry.
- d  input  WIDTH  data to push.
- qtop  output  WIDTH  entry 0 (top of stack).
- qnext  output  WIDTH  entry 1 (next of stack).
- count  output  CW  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- ovf  output  1  sticky overflow flag.
- udf  output  1  sticky underflow flag.

Behaviour:
- Clock and reset:
  - Reset rst_n is asynchronous, active-low; clock is clk.
  - All state updates on the rising edge of clk.
- Storage is a shift array q[0..DEPTH-1]:
  - q[0] is the top.
  - qtop = q[0] and qnext = q[1], combinational from registers, zero added latency.
- Reset values: all q = 0, count = 0, empty = 1, full = 0, ovf = 0, udf = 0.
  - Reset asserted mid-operation overrides everything immediately.
- Priority per cycle: clr > operation decode.
- clr = 1:
  - all q <= 0, count <= 0, ovf <= 0, udf <= 0.
  - push and pop ignored that cycle.
- push=1, pop=0:
  - q[0] <= d; q[i] <= q[i-1] for i = 1..DEPTH-1.
  - If not full: count + 1.
  - If full: the bottom entry q[DEPTH-1] is discarded, count stays DEPTH, ovf <= 1.
- push=0, pop=1:
  - If not empty: q[i] <= q[i+1]; q[DEPTH-1] <= 0; count - 1.
  - If empty: array and count unchanged, udf <= 1.
- push=1, pop=1 (replace top):
  - If not empty: q[0] <= d, rest unchanged, count unchanged, no flag change.
  - If empty: treated as a plain push (count becomes 1), udf unchanged.
- push=0, pop=0: hold.
- Popped and vacated slots always read 0: qnext = 0 when count <= 1; qtop = 0 when empty.
- Flags:
  - empty and full are decoded from registered count; no extra cycle of lag.
  - ovf and udf are sticky until clr or reset.
- count never exceeds DEPTH and never underflows below 0.

Optional Feature:
- Macro: STACK_SWAP_EN.
- Defined:
  - Adds input port swap (1 bit).
  - swap=1 with count >= 2: q[0] <= q[1] and q[1] <= q[0]; count unchanged.
  - swap=1 with count < 2: no data change, udf <= 1.
  - Priority is clr > swap > push/pop; push and pop are ignored in a swap cycle.
- Not defined:
  - No swap port exists.
  - Behaviour is exactly as described above.

Test Plan (DEPTH=4, WIDTH=16 unless stated):
- Reset, then push 0x1111, 0x2222, 0x3333 -> qtop=0x3333, qnext=0x2222, count=3, empty=0, full=0.
- From full (push 0xA,0xB,0xC,0xD), push 0xE -> count=4, full=1, ovf=1, qtop=0xE, qnext=0xD; pop 4 times -> E, D, C, B, empty=1; 0xA is lost.
- Pop on empty -> count=0, qtop=0, udf=1; then clr -> udf=0, ovf=0.
- Stack 0x0005, 0x0007; push=pop=1 with d=0x0009 -> qtop=0x0009, qnext=0x0005, count=2. Same operation on an empty stack with d=0x0042 -> count=1, qtop=0x0042.
- Push 0x1234, then assert rst_n=0 asynchronously between edges -> qtop=0, count=0, empty=1 before the next edge.
- STACK_SWAP_EN defined: stack 0x0001, 0x0002; swap=1 -> qtop=0x0001, qnext=0x0002. Swap with count=1 -> data unchanged, udf=1.
